// File: rtl/uart_temp_rx.sv
// UART receiver for 50-bit temperature-count frames: start, 32-bit count,
// 16'h0D0A trailer, stop. Emits the decoded count with a one-cycle strobe.
module uart_temp_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx_i,
  output logic [31:0] count_o,
  output logic        count_valid_o,
  output logic        frame_err_o,
  output logic        busy_o
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = ($clog2(CLKS_PER_BIT) > 9) ? $clog2(CLKS_PER_BIT) : 9;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
  localparam logic [15:0]   TRAILER   = 16'h0D0A;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic [1:0]    r_sync;
  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [5:0]    r_bit_idx;
  logic [47:0]   r_shift;
  logic [31:0]   r_count;
  logic          r_valid;
  logic          r_err;
  logic          w_rx_s;

  assign w_rx_s = r_sync[1];

  // Sync flops reset high so a released reset looks like an idle line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], uart_rx_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_timer <= '0;
          end
        end
        S_START: begin
          if (r_timer == HALF_LAST) begin
            r_timer <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (r_timer == BIT_LAST) begin
            r_shift   <= {w_rx_s, r_shift[47:1]};
            r_timer   <= '0;
            r_bit_idx <= r_bit_idx + 6'd1;
            if (r_bit_idx == 6'd47) r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          // Leave at mid-stop-bit so a start bit right after it is caught.
          if (r_timer == BIT_LAST) begin
            r_timer <= '0;
            if (!w_rx_s) begin
              r_err   <= 1'b1;
              r_state <= S_WAIT_HIGH;
            end else if (r_shift[47:32] == TRAILER) begin
              r_count <= r_shift[31:0];
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign count_o       = r_count;
  assign count_valid_o = r_valid;
  assign frame_err_o   = r_err;
  assign busy_o        = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_temp_rx.sv
// Randomized frame stimulus checked against a frame-level outcome model:
// each transmitted frame predicts one pulse (good/err) and the held count.
module tb_uart_temp_rx;
  localparam int CF   = 50_000_000;
  localparam int BR   = 1_000_000;
  localparam int BIT  = CF / BR;
  localparam int HALF = BIT / 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] count_o;
  logic        count_valid_o, frame_err_o, busy_o;

  uart_temp_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx_i(rx),
    .count_o(count_o), .count_valid_o(count_valid_o),
    .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          good;
    logic [31:0] val;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_count = '0;
  int          n_chk = 0, n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, act === exp, act, exp);
  endtask

  // Per-cycle compare against the frame-outcome model.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && chk_en) begin
      chk_eq("valid_err_exclusive", {31'b0, count_valid_o & frame_err_o}, 32'd0);
      if (count_valid_o || frame_err_o) begin
        if (q.size() == 0) begin
          chk_eq("unexpected_pulse", {30'b0, count_valid_o, frame_err_o}, 32'd0);
        end else begin
          e = q.pop_front();
          chk_eq("pulse_kind", {30'b0, count_valid_o, frame_err_o}, e.good ? 32'd2 : 32'd1);
          chk("pulse_latency", (cyc - e.t >= HALF) && (cyc - e.t <= HALF + 8),
              32'(cyc - e.t), 32'(HALF));
          if (e.good) begin
            chk_eq("count_on_valid", count_o, e.val);
            m_count = e.val;
          end else begin
            chk_eq("count_hold_on_err", count_o, m_count);
          end
        end
      end else begin
        chk_eq("count_hold", count_o, m_count);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // nbits < 50 truncates the frame (no outcome predicted).
  task automatic send_frame(input logic [31:0] cnt, input logic [15:0] trl, input bit stp,
                            input int nbits, input bit glitch);
    logic [49:0] f;
    exp_t e;
    f = {stp, trl, cnt, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < BIT; j++) begin
        @(negedge clk);
        if (i == 49 && j == 0) begin
          e.good = stp && (trl == 16'h0D0A);
          e.val  = cnt;
          e.t    = cyc;
          q.push_back(e);
        end
        rx = (glitch && i == 10 && j < 4) ? ~f[i] : f[i];
      end
    end
  endtask

  task automatic wait_q(input string nm);
    for (int k = 0; k < 4 * BIT && q.size() != 0; k++) @(negedge clk);
    chk_eq(nm, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    logic [15:0] t;
    bit          s;
    int          lowbusy;

    reset_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk_eq("reset_count", count_o, 32'd0);
    chk_eq("reset_valid", {31'b0, count_valid_o}, 32'd0);
    chk_eq("reset_err", {31'b0, frame_err_o}, 32'd0);
    chk_eq("reset_busy", {31'b0, busy_o}, 32'd0);
    reset_n = 1'b1;
    m_count = '0;
    chk_en  = 1'b1;
    idle(20);

    send_frame(32'h0000_1234, 16'h0D0A, 1'b1, 50, 1'b0);
    idle(HALF + 10);
    wait_q("single_frame_done");
    chk_eq("single_frame_literal", count_o, 32'h0000_1234);

    send_frame(32'hDEAD_BEEF, 16'h0D0A, 1'b1, 50, 1'b0);
    send_frame(32'h0000_0001, 16'h0D0A, 1'b1, 50, 1'b0);
    idle(HALF + 10);
    wait_q("back_to_back_done");
    chk_eq("back_to_back_literal", count_o, 32'h0000_0001);

    send_frame(32'h1111_2222, 16'h0D0B, 1'b1, 50, 1'b0);
    idle(HALF + 10);
    wait_q("bad_trailer_done");
    chk_eq("bad_trailer_literal", count_o, 32'h0000_0001);

    // Stop bit low, then the line stays low.
    send_frame(32'h5555_AAAA, 16'h0D0A, 1'b0, 50, 1'b0);
    lowbusy = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      rx = 1'b0;
      if (!busy_o) lowbusy++;
    end
    chk_eq("break_busy_low_cycles", 32'(lowbusy), 32'd0);
    chk_eq("break_single_err", 32'(q.size()), 32'd0);
    idle(5);
    chk_eq("break_release_busy", {31'b0, busy_o}, 32'd0);
    idle(10);

    // Glitch shorter than half a bit.
    for (int k = 0; k < HALF + 8; k++) begin
      @(negedge clk);
      rx = (k < HALF - 5) ? 1'b0 : 1'b1;
      if (k == 10) chk_eq("glitch_busy_started", {31'b0, busy_o}, 32'd1);
    end
    chk_eq("glitch_busy_cleared", {31'b0, busy_o}, 32'd0);
    idle(10);

    // Reset in the middle of a frame, then a clean frame.
    send_frame(32'h7777_7777, 16'h0D0A, 1'b1, 21, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    rx = 1'b1;
    m_count = '0;
    repeat (3) @(negedge clk);
    chk_eq("midframe_reset_count", count_o, 32'd0);
    reset_n = 1'b1;
    idle(10);
    send_frame(32'h0000_00FF, 16'h0D0A, 1'b1, 50, 1'b0);
    idle(HALF + 10);
    wait_q("after_reset_done");
    chk_eq("after_reset_literal", count_o, 32'h0000_00FF);

    // Boundary counts and a mid-bit line glitch.
    send_frame(32'hFFFF_FFFF, 16'h0D0A, 1'b1, 50, 1'b0);
    send_frame(32'h0000_0000, 16'h0D0A, 1'b1, 50, 1'b1);
    idle(HALF + 10);
    wait_q("boundary_done");
    chk_eq("boundary_zero_literal", count_o, 32'h0000_0000);

    for (int n = 0; n < 14; n++) begin
      c = $urandom;
      t = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0D0A;
      s = ($urandom_range(0, 5) != 0);
      send_frame(c, t, s, 50, $urandom_range(0, 1) == 1);
      idle(s ? $urandom_range(0, 20) : $urandom_range(5, 20));
    end
    idle(HALF + 10);
    wait_q("random_done");

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
